// File: rtl/mips_alu_seq.sv
// mips_alu_seq: EX-stage MIPS ALU with registered single-cycle ops
// and iterative multiply/divide writing the HI/LO pair.
module mips_alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             out_valid
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLTU  = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_MULT  = 4'd9;
  localparam logic [3:0] OP_MULTU = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               w_accept;
  logic               w_run;
  logic               w_fix;
  logic               w_is_md;
  logic               w_is_div;
  logic               w_sgn;
  logic               w_last;

  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_bz;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_dif;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mstep;
  logic [WIDTH:0]     w_dsh;
  logic [WIDTH:0]     w_ddif;
  logic [2*WIDTH-1:0] w_dstep;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  always_comb begin
    w_is_md  = (ALUCtl == OP_MULT) || (ALUCtl == OP_MULTU) ||
               (ALUCtl == OP_DIV)  || (ALUCtl == OP_DIVU);
    w_is_div = (ALUCtl == OP_DIV) || (ALUCtl == OP_DIVU);
    w_sgn    = (ALUCtl == OP_MULT) || (ALUCtl == OP_DIV);
    w_last   = (r_cnt == SHW'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && w_is_md) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = (r_state == S_IDLE) && !reset;
    w_accept = start && ready;
    w_run    = (r_state == S_RUN);
    w_fix    = (r_state == S_FIX);
  end

  always_comb begin
    w_sum = A + B;
    w_dif = A - B;
    w_res = '0;
    w_ovf = 1'b0;
    unique case (ALUCtl)
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_NOR:  w_res = ~(A | B);
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                (w_dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  w_res = B << Shamt;
      OP_SRL:  w_res = B >> Shamt;
      OP_SRA:  w_res = $unsigned($signed(B) >>> Shamt);
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_abs_a = (w_sgn && A[WIDTH-1]) ? -A : A;
    w_abs_b = (w_sgn && B[WIDTH-1]) ? -B : B;
  end

  // Upper half of r_acc is the partial product / remainder,
  // lower half the multiplier / dividend shifting out.
  always_comb begin
    w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
              (r_acc[0] ? {1'b0, r_opb} : '0);
    w_mstep = {w_madd, r_acc[WIDTH-1:1]};
    w_dsh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ddif  = w_dsh - {1'b0, r_opb};
    w_dstep = w_ddif[WIDTH] ?
              {w_dsh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0} :
              {w_ddif[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    if (r_div) begin
      w_hi_fix = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                         : r_acc[2*WIDTH-1:WIDTH];
      w_lo_fix = r_bz ? '1 : w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUOut    <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      out_valid <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_div     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_bz      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (w_accept && !w_is_md) begin
        ALUOut    <= w_res;
        Zero      <= (w_res == '0);
        Overflow  <= w_ovf;
        out_valid <= 1'b1;
      end
      if (w_accept && w_is_md) begin
        r_cnt   <= '0;
        r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
        r_opb   <= w_abs_b;
        r_div   <= w_is_div;
        r_neg_q <= w_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
        r_neg_r <= w_sgn && A[WIDTH-1];
        r_bz    <= (B == '0);
      end
      if (w_run) begin
        r_acc <= r_div ? w_dstep : w_mstep;
        r_cnt <= r_cnt + SHW'(1);
      end
      if (w_fix) begin
        r_hi      <= w_hi_fix;
        r_lo      <= w_lo_fix;
        ALUOut    <= w_lo_fix;
        Zero      <= (w_lo_fix == '0);
        Overflow  <= 1'b0;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_seq.sv
// tb_mips_alu_seq: directed and random checks of mips_alu_seq
// at WIDTH=8 and WIDTH=32 against an arithmetic reference model.
module tb_mips_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        st  [2];
  logic [3:0]  ctl [2];
  logic [31:0] a   [2];
  logic [31:0] b   [2];
  logic [4:0]  sh  [2];

  logic        rdy8, z8, ov8, v8;
  logic [7:0]  o8;
  logic        rdy32, z32, ov32, v32;
  logic [31:0] o32;

  mips_alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .ready(rdy8),
    .ALUCtl(ctl[0]), .A(a[0][7:0]), .B(b[0][7:0]),
    .Shamt(sh[0][2:0]), .ALUOut(o8), .Zero(z8),
    .Overflow(ov8), .out_valid(v8)
  );

  mips_alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .ready(rdy32),
    .ALUCtl(ctl[1]), .A(a[1]), .B(b[1]),
    .Shamt(sh[1]), .ALUOut(o32), .Zero(z32),
    .Overflow(ov32), .out_valid(v32)
  );

  int checks = 0;
  int errors = 0;
  int cur_w  = 32;

  longint unsigned m_hi [2];
  longint unsigned m_lo [2];
  longint unsigned p_hi [2];
  longint unsigned p_lo [2];
  longint unsigned e_out [2];
  bit              e_ovf [2];
  bit              e_v   [2];
  int              busy  [2];

  longint unsigned so_out;
  bit so_v, so_z, so_ov, so_rdy;

  task automatic check(input string nm, input longint unsigned act,
                       input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (W=%0d): got %0h expected %0h",
               nm, cur_w, act, exp);
    end
  endtask

  function automatic longint sx(input longint unsigned v, input int w);
    longint unsigned m;
    m = (64'd1 << w) - 1;
    if (v[w-1]) return $signed(v | ~m);
    return $signed(v & m);
  endfunction

  function automatic void ref_op(
    input int w, input int op,
    input longint unsigned av, input longint unsigned bv, input int s,
    inout longint unsigned hi, inout longint unsigned lo,
    output longint unsigned res, output bit ovf);
    longint unsigned m, p;
    longint sa, sb, t, mx, mn;
    m   = (64'd1 << w) - 1;
    sa  = sx(av, w);
    sb  = sx(bv, w);
    mx  = (64'sd1 <<< (w-1)) - 1;
    mn  = -mx - 1;
    res = 0;
    ovf = 0;
    case (op)
      0: res = av & bv;
      1: res = av | bv;
      2: begin t = sa + sb; res = $unsigned(t) & m; ovf = (t > mx) || (t < mn); end
      3: res = (av < bv) ? 1 : 0;
      4: res = (bv << s) & m;
      5: res = bv >> s;
      6: begin t = sa - sb; res = $unsigned(t) & m; ovf = (t > mx) || (t < mn); end
      7: res = (sa < sb) ? 1 : 0;
      8: res = $unsigned(sb >>> s) & m;
      9: begin
        p = $unsigned(sa * sb);
        hi = (p >> w) & m; lo = p & m; res = lo;
      end
      10: begin
        p = av * bv;
        hi = (p >> w) & m; lo = p & m; res = lo;
      end
      11: begin
        if (bv == 0) begin lo = m; hi = av; end
        else begin
          lo = $unsigned(sa / sb) & m;
          hi = $unsigned(sa % sb) & m;
        end
        res = lo;
      end
      12: res = ~(av | bv) & m;
      13: begin
        if (bv == 0) begin lo = m; hi = av; end
        else begin lo = av / bv; hi = av % bv; end
        res = lo;
      end
      14: res = hi;
      15: res = lo;
      default: res = 0;
    endcase
  endfunction

  task automatic sample(input int k);
    if (k == 0) begin
      so_out = o8;  so_v = v8;  so_z = z8;  so_ov = ov8;  so_rdy = rdy8;
    end else begin
      so_out = o32; so_v = v32; so_z = z32; so_ov = ov32; so_rdy = rdy32;
    end
  endtask

  // One clock cycle: drive, predict, and compare all outputs.
  task automatic cyc(input int k, input bit r, input bit s, input int op,
                     input longint unsigned av, input longint unsigned bv,
                     input int shv);
    int w;
    longint unsigned m, res, h, l, am, bm;
    bit er, acc, ovf;
    w     = k ? 32 : 8;
    cur_w = w;
    m     = (64'd1 << w) - 1;
    am    = av & m;
    bm    = bv & m;
    rst[k] = r;
    st[k]  = s;
    ctl[k] = 4'(op);
    a[k]   = 32'(am);
    b[k]   = 32'(bm);
    sh[k]  = 5'(shv % w);
    #1;
    sample(k);
    er  = !r && (busy[k] == 0);
    check("ready", so_rdy, er);
    acc = s && er;
    @(posedge clk);
    e_v[k] = 0;
    if (r) begin
      m_hi[k] = 0; m_lo[k] = 0; busy[k] = 0;
      e_out[k] = 0; e_ovf[k] = 0;
    end else if (busy[k] > 0) begin
      busy[k]--;
      if (busy[k] == 0) begin
        m_hi[k] = p_hi[k]; m_lo[k] = p_lo[k];
        e_out[k] = p_lo[k]; e_ovf[k] = 0; e_v[k] = 1;
      end
    end else if (acc) begin
      h = m_hi[k];
      l = m_lo[k];
      ref_op(w, op, am, bm, shv % w, h, l, res, ovf);
      if (op == 9 || op == 10 || op == 11 || op == 13) begin
        p_hi[k] = h; p_lo[k] = l; busy[k] = w + 1;
      end else begin
        e_out[k] = res; e_ovf[k] = ovf; e_v[k] = 1;
      end
    end
    @(negedge clk);
    sample(k);
    check("out_valid", so_v, e_v[k]);
    check("ALUOut", so_out, e_out[k]);
    check("Zero", so_z, e_out[k] == 0);
    check("Overflow", so_ov, e_ovf[k]);
  endtask

  task automatic md(input int k, input int op,
                    input longint unsigned av, input longint unsigned bv);
    int w;
    w = k ? 32 : 8;
    cyc(k, 0, 1, op, av, bv, 0);
    for (int j = 0; j <= w; j++)
      cyc(k, 0, j[0], $urandom_range(0, 15), $urandom, $urandom, 0);
    check("md_latency_valid", so_v, 1);
  endtask

  function automatic longint unsigned rnd_opnd(input int w);
    longint unsigned m;
    m = (64'd1 << w) - 1;
    case ($urandom_range(0, 7))
      0: return 0;
      1: return m;
      2: return 64'd1 << (w-1);
      3: return 1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  initial begin
    longint unsigned h, l, r;
    bit o;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1; st[k] = 0; ctl[k] = 0; a[k] = 0; b[k] = 0; sh[k] = 0;
      m_hi[k] = 0; m_lo[k] = 0; p_hi[k] = 0; p_lo[k] = 0;
      e_out[k] = 0; e_ovf[k] = 0; e_v[k] = 0; busy[k] = 0;
    end

    h = 0; l = 0;
    ref_op(8, 11, 64'h80, 64'hFF, 0, h, l, r, o);
    check("model_div8_lo", l, 64'h80);
    check("model_div8_hi", h, 0);
    ref_op(32, 9, 64'hFFFFFFFD, 7, 0, h, l, r, o);
    check("model_mult_lo", l, 64'hFFFFFFEB);
    check("model_mult_hi", h, 64'hFFFFFFFF);

    @(negedge clk);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("rst_out", so_out, 0);
    check("rst_zero", so_z, 1);

    cyc(1, 0, 1, 2, 64'h7FFFFFFF, 1, 0);
    check("add_out", so_out, 64'h80000000);
    check("add_ovf", so_ov, 1);
    check("add_zero", so_z, 0);
    cyc(1, 0, 1, 6, 5, 5, 0);
    check("sub_out", so_out, 0);
    check("sub_zero", so_z, 1);
    cyc(1, 0, 1, 7, 64'hFFFFFFFF, 1, 0);
    check("slt_out", so_out, 1);
    cyc(1, 0, 1, 3, 64'hFFFFFFFF, 1, 0);
    check("sltu_out", so_out, 0);
    cyc(1, 0, 1, 8, 0, 64'h80000000, 4);
    check("sra_out", so_out, 64'hF8000000);

    md(1, 9, 64'hFFFFFFFD, 7);
    check("mult_lo", so_out, 64'hFFFFFFEB);
    cyc(1, 0, 1, 14, 0, 0, 0);
    check("mult_hi", so_out, 64'hFFFFFFFF);

    md(1, 11, 64'hFFFFFFF9, 2);
    check("div_lo", so_out, 64'hFFFFFFFD);
    cyc(1, 0, 1, 14, 0, 0, 0);
    check("div_hi", so_out, 64'hFFFFFFFF);

    md(1, 13, 7, 0);
    check("divu0_lo", so_out, 64'hFFFFFFFF);
    cyc(1, 0, 1, 14, 0, 0, 0);
    check("divu0_hi", so_out, 7);

    md(1, 11, 64'h80000000, 64'hFFFFFFFF);
    check("divovf_lo", so_out, 64'h80000000);
    cyc(1, 0, 1, 14, 0, 0, 0);
    check("divovf_hi", so_out, 0);

    md(1, 10, 64'hFFFFFFFF, 64'hFFFFFFFF);
    check("multu_lo", so_out, 1);
    cyc(1, 0, 1, 14, 0, 0, 0);
    check("multu_hi", so_out, 64'hFFFFFFFE);

    cyc(1, 0, 1, 9, 5, 6, 0);
    for (int j = 0; j < 10; j++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("post_rst_ready", so_rdy, 1);
    cyc(1, 0, 1, 14, 0, 0, 0);
    check("post_rst_mfhi", so_out, 0);
    st[1] = 0;

    for (int k = 0; k < 2; k++) begin
      int w;
      w = k ? 32 : 8;
      cyc(k, 1, 0, 0, 0, 0, 0);
      cyc(k, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2500; i++)
        cyc(k, $urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15), rnd_opnd(w), rnd_opnd(w),
            $urandom_range(0, 31));
      st[k] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
